// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared types for the instruction fetch unit: scalar aliases, the fetch
// state encoding, the queue entry layout and a width helper for occupancy
// counters.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    typedef logic        Clock;
    typedef logic        Bool;
    typedef logic [31:0] Addr;
    typedef logic [31:0] Word;

    // IDLE : no request outstanding
    // WAIT : one request accepted, response pending
    // DRAIN: request outstanding but squashed by a flush
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } FetchState;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        Addr addr;
        Word data;
    } fetch_entry_t;

    // Occupancy must be able to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Instruction-memory read port: a valid/ready request channel carrying the
// fetch address and a valid-only response channel carrying the instruction.
//   master : fetch unit side (drives request, receives response)
//   slave  : memory side
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    Bool req_valid;
    Bool req_ready;
    Addr req_addr;
    Bool resp_valid;
    Word resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO of fetched instructions between memory and decode.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push, push_entry  write an entry at the tail
//   pop               remove the head entry
//   clear             drop all entries (takes priority over push/pop)
//   full, empty       occupancy flags
//   head              entry at the head of the queue
//   count             current occupancy (0..QUEUE_DEPTH)
// A simultaneous push and pop on a full queue is legal: the popped slot is
// the one being refilled, and the head is read before the edge.
// -----------------------------------------------------------------------------
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  Clock                                   clk,
    input  Bool                                    reset,
    input  Bool                                    push,
    input  fetch_entry_t                           push_entry,
    input  Bool                                    pop,
    input  Bool                                    clear,
    output Bool                                    full,
    output Bool                                    empty,
    output fetch_entry_t                           head,
    output logic [count_width(QUEUE_DEPTH)-1:0]    count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = count_width(QUEUE_DEPTH);

    fetch_entry_t     entries_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // NOTE: every variable assigned here gets its hold value first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; count/pointers alone
    // decide which slots are meaningful, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push && !clear) entries_q[wr_ptr_q] <= push_entry;
    end

    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(QUEUE_DEPTH));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty && !clear));

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetches instructions from memory at the program-counter address and
// buffers them for decode. At most one memory request is in flight; a flush
// (taken jump) empties the buffer and squashes any pending response.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   pc_address      current fetch address from the program counter
//   pc_stall        1 = hold the PC; 0 = PC advances this edge
//   flush           jump taken; PC loads the target on the same edge
//   mem             instruction-memory port (master side)
//   inst_valid/ready/data/addr   decode-side handshake, head of the queue
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2   // 2 or 4
) (
    input  Clock                        clk,
    input  Bool                         reset,
    input  Addr                         pc_address,
    output Bool                         pc_stall,
    input  Bool                         flush,
    instruction_fetch_if.master         mem,
    output Bool                         inst_valid,
    input  Bool                         inst_ready,
    output Word                         inst_data,
    output Addr                         inst_addr
);

    localparam int CNT_W = count_width(QUEUE_DEPTH);

    FetchState        state_q, state_d;
    Addr              pend_addr_q, pend_addr_d;
    Bool              rst_hold_q;     // high on the first cycle after reset

    Bool              blocked;
    Bool              resp_in_wait;
    Bool              resp_accept;
    Bool              req_fire;
    Bool              q_push, q_pop, q_full, q_empty;
    fetch_entry_t     q_head, q_wr_entry;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] occupancy;

    // Requests are suppressed while reset is asserted and for one cycle after,
    // so nothing is issued before the PC has settled.
    assign blocked      = reset || rst_hold_q;
    assign resp_in_wait = (state_q == WAIT) && mem.resp_valid;
    // Buffered entries plus the one in flight; this keeps a slot reserved
    // for every outstanding response so the queue can never overflow.
    assign occupancy    = q_count + CNT_W'(state_q == WAIT);

    assign mem.req_valid = !blocked && !flush
                        && ((state_q == IDLE) || resp_in_wait)
                        && (occupancy < CNT_W'(QUEUE_DEPTH));
    assign mem.req_addr  = pc_address;
    assign req_fire      = mem.req_valid && mem.req_ready;
    assign pc_stall      = blocked || !(req_fire || flush);

    assign resp_accept = resp_in_wait && !flush;
    assign q_push      = resp_accept && (!q_full || q_pop);
    assign q_pop       = inst_valid && inst_ready;
    assign q_wr_entry  = '{addr: pend_addr_q, data: mem.resp_data};

    assign inst_valid = !reset && !q_empty;
    assign inst_data  = q_head.data;
    assign inst_addr  = q_head.addr;

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        if (req_fire) pend_addr_d = pc_address;
        case (state_q)
            IDLE:  if (req_fire) state_d = WAIT;
            WAIT: begin
                // A flush with the response in hand simply discards it;
                // without it, the late response must still be swallowed.
                if (mem.resp_valid) state_d = req_fire ? WAIT : IDLE;
                else if (flush)     state_d = DRAIN;
            end
            DRAIN: if (mem.resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            rst_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            rst_hold_q  <= 1'b0;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_entry (q_wr_entry),
        .pop        (q_pop),
        .clear      (flush),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head),
        .count      (q_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        resp_accept |-> (!q_full || q_pop));

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch (QUEUE_DEPTH = 2). Inputs change 1ns
// after the rising edge, outputs are sampled 1ns later. The status vector is
// {mem_req_valid, pc_stall, inst_valid}.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    Clock clk = 1'b0;
    Bool  reset;
    Addr  pc_address;
    Bool  pc_stall;
    Bool  flush;
    Bool  inst_valid;
    Bool  inst_ready;
    Word  inst_data;
    Addr  inst_addr;

    instruction_fetch_if mem_bus ();

    instruction_fetch #(
        .QUEUE_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_address (pc_address),
        .pc_stall   (pc_stall),
        .flush      (flush),
        .mem        (mem_bus),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_addr  (inst_addr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0]  st;
    logic [63:0] hd;
    assign st = {mem_bus.req_valid, pc_stall, inst_valid};
    assign hd = {inst_addr, inst_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_defaults();
        flush              = 1'b0;
        inst_ready         = 1'b0;
        pc_address         = 32'h0;
        mem_bus.req_ready  = 1'b1;
        mem_bus.resp_valid = 1'b0;
        mem_bus.resp_data  = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_defaults();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_defaults();
        tick();
        tick();
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL reset_active: status %b, expected %b", st, 3'b010); end
        reset = 1'b0;
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL reset_hold: status %b, expected %b", st, 3'b010); end
        tick();
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL reset_release: status %b, expected %b", st, 3'b100); end
        n_vec++; if (mem_bus.req_addr !== 32'h0) begin n_err++; $display("FAIL reset_req_addr: got %h, expected %h", mem_bus.req_addr, 32'h0); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        pc_address = 32'h0;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL basic_req: status %b, expected %b", st, 3'b100); end
        tick();
        pc_address = 32'h4; mem_bus.req_ready = 1'b0;
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h0000_0013;
        #1;
        n_vec++; if (st !== 3'b110) begin n_err++; $display("FAIL basic_resp: status %b, expected %b", st, 3'b110); end
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        n_vec++; if (st !== 3'b111) begin n_err++; $display("FAIL basic_inst: status %b, expected %b", st, 3'b111); end
        n_vec++; if (hd !== {32'h0, 32'h0000_0013}) begin n_err++; $display("FAIL basic_head: got %h, expected %h", hd, {32'h0, 32'h0000_0013}); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b110) begin n_err++; $display("FAIL basic_pop: status %b, expected %b", st, 3'b110); end
    endtask

    task automatic test_queue_full();
        do_reset();
        pc_address = 32'h0;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL full_req0: status %b, expected %b", st, 3'b100); end
        tick();
        pc_address = 32'h4; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h1111_1111;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL full_req4: status %b, expected %b", st, 3'b100); end
        n_vec++; if (mem_bus.req_addr !== 32'h4) begin n_err++; $display("FAIL full_addr4: got %h, expected %h", mem_bus.req_addr, 32'h4); end
        tick();
        pc_address = 32'h8; mem_bus.resp_data = 32'h2222_2222;
        #1;
        n_vec++; if (st !== 3'b011) begin n_err++; $display("FAIL full_noreq8: status %b, expected %b", st, 3'b011); end
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        n_vec++; if (st !== 3'b011) begin n_err++; $display("FAIL full_held: status %b, expected %b", st, 3'b011); end
        n_vec++; if (hd !== {32'h0, 32'h1111_1111}) begin n_err++; $display("FAIL full_head0: got %h, expected %h", hd, {32'h0, 32'h1111_1111}); end
        tick();
        inst_ready = 1'b1;
        #1;
        n_vec++; if (st !== 3'b011) begin n_err++; $display("FAIL full_popcycle: status %b, expected %b", st, 3'b011); end
        tick();
        inst_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b101) begin n_err++; $display("FAIL full_resume: status %b, expected %b", st, 3'b101); end
        n_vec++; if (mem_bus.req_addr !== 32'h8) begin n_err++; $display("FAIL full_addr8: got %h, expected %h", mem_bus.req_addr, 32'h8); end
        n_vec++; if (hd !== {32'h4, 32'h2222_2222}) begin n_err++; $display("FAIL full_head4: got %h, expected %h", hd, {32'h4, 32'h2222_2222}); end
    endtask

    task automatic test_flush_drain();
        do_reset();
        pc_address = 32'h8;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL drain_req8: status %b, expected %b", st, 3'b100); end
        tick();
        flush = 1'b1;
        #1;
        n_vec++; if (st !== 3'b000) begin n_err++; $display("FAIL drain_flush: status %b, expected %b", st, 3'b000); end
        tick();
        flush = 1'b0; pc_address = 32'h100;
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL drain_wait1: status %b, expected %b", st, 3'b010); end
        tick();
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL drain_wait2: status %b, expected %b", st, 3'b010); end
        tick();
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL drain_stale: status %b, expected %b", st, 3'b010); end
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL drain_target: status %b, expected %b", st, 3'b100); end
        n_vec++; if (mem_bus.req_addr !== 32'h100) begin n_err++; $display("FAIL drain_addr: got %h, expected %h", mem_bus.req_addr, 32'h100); end
        tick();
        pc_address = 32'h104; mem_bus.req_ready = 1'b0;
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h0000_0093;
        #1;
        n_vec++; if (st !== 3'b110) begin n_err++; $display("FAIL drain_resp: status %b, expected %b", st, 3'b110); end
        tick();
        mem_bus.resp_valid = 1'b0;
        #1;
        n_vec++; if (st !== 3'b111) begin n_err++; $display("FAIL drain_inst: status %b, expected %b", st, 3'b111); end
        n_vec++; if (hd !== {32'h100, 32'h0000_0093}) begin n_err++; $display("FAIL drain_head: got %h, expected %h", hd, {32'h100, 32'h0000_0093}); end
    endtask

    task automatic test_flush_with_resp();
        do_reset();
        pc_address = 32'hC;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL fresp_reqC: status %b, expected %b", st, 3'b100); end
        tick();
        pc_address = 32'h10; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h0000_0C0C;
        #1;
        n_vec++; if (mem_bus.req_addr !== 32'h10 || st !== 3'b100) begin n_err++; $display("FAIL fresp_req10: status %b addr %h, expected %b addr %h", st, mem_bus.req_addr, 3'b100, 32'h10); end
        tick();
        flush = 1'b1; mem_bus.resp_data = 32'h0000_1010;
        #1;
        n_vec++; if (st !== 3'b001) begin n_err++; $display("FAIL fresp_flush: status %b, expected %b", st, 3'b001); end
        n_vec++; if (hd !== {32'hC, 32'h0000_0C0C}) begin n_err++; $display("FAIL fresp_head: got %h, expected %h", hd, {32'hC, 32'h0000_0C0C}); end
        tick();
        flush = 1'b0; mem_bus.resp_valid = 1'b0; pc_address = 32'h200; mem_bus.req_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b110) begin n_err++; $display("FAIL fresp_idle: status %b, expected %b", st, 3'b110); end
        tick();
        mem_bus.req_ready = 1'b1;
        #1;
        n_vec++; if (mem_bus.req_addr !== 32'h200 || st !== 3'b100) begin n_err++; $display("FAIL fresp_target: status %b addr %h, expected %b addr %h", st, mem_bus.req_addr, 3'b100, 32'h200); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pc_address = 32'h0;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL b2b_req0: status %b, expected %b", st, 3'b100); end
        tick();
        pc_address = 32'h4; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'hA0A0_0000;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL b2b_req4: status %b, expected %b", st, 3'b100); end
        tick();
        pc_address = 32'h8; mem_bus.resp_data = 32'hA4A4_0004;
        #1;
        n_vec++; if (st !== 3'b011) begin n_err++; $display("FAIL b2b_fill: status %b, expected %b", st, 3'b011); end
        tick();
        mem_bus.resp_valid = 1'b0; inst_ready = 1'b1;
        #1;
        n_vec++; if (st !== 3'b011 || hd !== {32'h0, 32'hA0A0_0000}) begin n_err++; $display("FAIL b2b_full: status %b head %h, expected %b head %h", st, hd, 3'b011, {32'h0, 32'hA0A0_0000}); end
        tick();
        inst_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b101 || mem_bus.req_addr !== 32'h8) begin n_err++; $display("FAIL b2b_req8: status %b addr %h, expected %b addr %h", st, mem_bus.req_addr, 3'b101, 32'h8); end
        tick();
        pc_address = 32'hC; inst_ready = 1'b1;
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'hA8A8_0008;
        #1;
        n_vec++; if (st !== 3'b011 || hd !== {32'h4, 32'hA4A4_0004}) begin n_err++; $display("FAIL b2b_pushpop: status %b head %h, expected %b head %h", st, hd, 3'b011, {32'h4, 32'hA4A4_0004}); end
        tick();
        mem_bus.resp_valid = 1'b0; inst_ready = 1'b0; mem_bus.req_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b111 || hd !== {32'h8, 32'hA8A8_0008}) begin n_err++; $display("FAIL b2b_order: status %b head %h, expected %b head %h", st, hd, 3'b111, {32'h8, 32'hA8A8_0008}); end
        tick();
        inst_ready = 1'b1;
        #1;
        tick();
        inst_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b110) begin n_err++; $display("FAIL b2b_drained: status %b, expected %b", st, 3'b110); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        pc_address = 32'h20;
        #1;
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL rwait_req: status %b, expected %b", st, 3'b100); end
        tick();
        reset = 1'b1;
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL rwait_reset: status %b, expected %b", st, 3'b010); end
        tick();
        reset = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'hBAD0_0BAD;
        #1;
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL rwait_hold: status %b, expected %b", st, 3'b010); end
        tick();
        mem_bus.resp_valid = 1'b0; mem_bus.req_ready = 1'b0;
        #1;
        n_vec++; if (st !== 3'b110) begin n_err++; $display("FAIL rwait_ignored: status %b, expected %b", st, 3'b110); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_queue_full();
        test_flush_drain();
        test_flush_with_resp();
        test_back_to_back();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2, number of fetched-instruction entries buffered (allowed values 2 or 4).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_address  input  Addr  current fetch address from the program counter.
REQ-005 pc_stall  output  1  holds the program counter (Bool); low = PC advances this edge.
REQ-006 flush  input  1  jump taken this cycle; PC loads jump target on the same edge.
REQ-007 mem_req_valid  output  1  instruction-memory read request valid.
REQ-008 mem_req_ready  input  1  memory accepts request.
REQ-009 mem_req_addr  output  Addr  request address.
REQ-010 mem_resp_valid  input  1  read data valid, ≥1 cycle after acceptance.
REQ-011 mem_resp_data  input  Word  32-bit instruction.
REQ-012 inst_valid  output  1  decode-side instruction valid.
REQ-013 inst_ready  input  1  decode accepts instruction.
REQ-014 inst_data  output  Word  instruction at queue head.
REQ-015 inst_addr  output  Addr  address of instruction at queue head.

Function
REQ-016 States: IDLE (no request outstanding), WAIT (one request accepted, response pending), DRAIN (request outstanding but squashed by flush).
REQ-017 At most one memory request outstanding at any time.
REQ-018 mem_req_valid high only in IDLE, or in WAIT on the cycle its response arrives, when queue occupancy plus outstanding count < QUEUE_DEPTH, and flush low.
REQ-019 mem_req_addr = pc_address combinationally; mem_req_valid, once high, stays high with stable address until mem_req_ready or flush.
REQ-020 Request handshake (mem_req_valid && mem_req_ready): capture pc_address as pending address, go to WAIT.
REQ-021 pc_stall = !(mem_req_valid && mem_req_ready) && !flush; PC advances exactly once per accepted request or on flush.
REQ-022 In WAIT, mem_resp_valid writes {pending address, mem_resp_data} into queue tail; state → IDLE unless a new request is accepted the same cycle (then stays WAIT).
REQ-023 Queue is FIFO; inst_valid = queue not empty; inst_data/inst_addr from head; head pops on inst_valid && inst_ready.
REQ-024 Simultaneous push and pop on a full queue is legal; occupancy unchanged.
REQ-025 Queue write when full cannot occur (guaranteed by REQ-018); assertion flags violation.
REQ-026 Pointers wrap modulo QUEUE_DEPTH; occupancy counter width clog2(QUEUE_DEPTH)+1.
REQ-027 flush: queue emptied on that edge (inst_valid low next cycle); a pop in the flush cycle is still honoured.
REQ-028 flush in WAIT without same-cycle response → DRAIN; flush in WAIT with same-cycle response → response discarded, IDLE.
REQ-029 In DRAIN, next mem_resp_valid is discarded (no queue write), state → IDLE; no request issued while in DRAIN.
REQ-030 flush in IDLE or DRAIN: state unchanged apart from queue clear.
REQ-031 Latency: request accepted cycle N, response cycle N+k → inst_valid at N+k+1.

Reset
REQ-032 On reset: state IDLE, queue empty, pointers and occupancy 0, pending address 0.
REQ-033 During and on the cycle after reset: inst_valid 0, mem_req_valid 0, pc_stall 1.
REQ-034 Response arriving for a request accepted before reset is discarded.

Structure
REQ-035 Shared package holds Addr, Word, Bool, Clock types and the fetch state enum FetchState {IDLE, WAIT, DRAIN}.
REQ-036 Queue is sub-module fetch_queue (parameter QUEUE_DEPTH; push, pop, clear, full, empty, head).
REQ-037 No latches; state machine in one always_ff block, next-state logic combinational.

Verification
REQ-038 Reset, then pc_address=0x0, mem_req_ready=1, 1-cycle memory returning 0x00000013 → inst_valid with inst_addr 0x0, inst_data 0x00000013, 2 cycles after request.
REQ-039 inst_ready=0, continuous fetch 0x0,0x4,0x8 → queue holds 0x0,0x4; mem_req_valid low, pc_stall high until first pop.
REQ-040 Request 0x8 accepted, flush next cycle, response 0xDEADBEEF arrives 3 cycles later → discarded, no inst_valid for 0x8, next request uses jump target 0x100.
REQ-041 flush in same cycle as response for 0x10 → response discarded, state IDLE, queue empty next cycle.
REQ-042 Full queue with inst_ready=1 and response arriving same cycle → occupancy remains 2, order 0x4 then 0x8 preserved.
REQ-043 Reset asserted in WAIT with response next cycle → response ignored, inst_valid 0, mem_req_valid 0 during reset.
